// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with Hi/Lo result registers.
// Shift-add multiply and restoring divide retire one bit per cycle, followed by
// a sign-correction cycle. Define MDU_DIV_EN to build the divider. Without it,
// ops 2-3 complete as reserved (illegal_op) ops.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             illegal_op,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              illegal_reg, illegal_next;
    logic [WIDTH-1:0]  hi_reg, hi_next;
    logic [WIDTH-1:0]  lo_reg, lo_next;
    logic [WIDTH-1:0]  b_reg, b_next;          // multiplicand / divisor magnitude
    logic [WIDTH-1:0]  acc_hi_reg, acc_hi_next; // product high half / remainder
    logic [WIDTH-1:0]  acc_lo_reg, acc_lo_next; // multiplier bits / quotient bits
    logic              neg_reg, neg_next;      // product or quotient must be negated
`ifdef MDU_DIV_EN
    logic              is_div_reg, is_div_next;
    logic              neg_r_reg, neg_r_next;  // remainder takes dividend sign
    logic              div0_reg, div0_next;
    logic [WIDTH-1:0]  a_raw_reg, a_raw_next;  // raw dividend for divide-by-zero
    logic [WIDTH:0]    shifted;
    logic [WIDTH+1:0]  diff;
    logic [WIDTH-1:0]  q_fix, r_fix;
`endif

    logic              is_mul, is_div_op, signed_op, sa, sb;
    logic [WIDTH-1:0]  am, bm;
    logic [WIDTH:0]    sum;
    logic [2*WIDTH-1:0] prod;

    // Decode and operand magnitudes
    always_comb begin
        is_mul    = (op == 3'd0) || (op == 3'd1);
`ifdef MDU_DIV_EN
        is_div_op = (op == 3'd2) || (op == 3'd3);
`else
        is_div_op = 1'b0;
`endif
        signed_op = (op == 3'd0) || (op == 3'd2);
        sa        = signed_op & rs[WIDTH-1];
        sb        = signed_op & rt[WIDTH-1];
        am        = sa ? -rs : rs;
        bm        = sb ? -rt : rt;
    end

    // Next-state, datapath iteration and result write-back
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        illegal_next = 1'b0;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        b_next       = b_reg;
        acc_hi_next  = acc_hi_reg;
        acc_lo_next  = acc_lo_reg;
        neg_next     = neg_reg;
        sum          = '0;
        prod         = {acc_hi_reg, acc_lo_reg};
`ifdef MDU_DIV_EN
        is_div_next  = is_div_reg;
        neg_r_next   = neg_r_reg;
        div0_next    = div0_reg;
        a_raw_next   = a_raw_reg;
        shifted      = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        diff         = {1'b0, shifted} - {2'b00, b_reg};
        q_fix        = neg_reg ? -acc_lo_reg : acc_lo_reg;
        r_fix        = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (is_mul || is_div_op) begin
                        state_next  = CALC;
                        busy_next   = 1'b1;
                        cnt_next    = '0;
                        b_next      = bm;
                        acc_hi_next = '0;
                        acc_lo_next = am;
                        neg_next    = sa ^ sb;
`ifdef MDU_DIV_EN
                        is_div_next = is_div_op;
                        neg_r_next  = sa;
                        div0_next   = (rt == '0);
                        a_raw_next  = rs;
`endif
                    end else if (op == 3'd4) begin
                        hi_next   = rs;
                        done_next = 1'b1;
                    end else if (op == 3'd5) begin
                        lo_next   = rs;
                        done_next = 1'b1;
                    end else begin
                        done_next    = 1'b1;
                        illegal_next = 1'b1;
                    end
                end
            end
            CALC: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = FIN;
                end
`ifdef MDU_DIV_EN
                if (is_div_reg) begin
                    if (!diff[WIDTH+1]) begin
                        acc_hi_next = diff[WIDTH-1:0];
                        acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_next = shifted[WIDTH-1:0];
                        acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    sum         = acc_lo_reg[0] ? ({1'b0, acc_hi_reg} + {1'b0, b_reg})
                                                : {1'b0, acc_hi_reg};
                    acc_hi_next = sum[WIDTH:1];
                    acc_lo_next = {sum[0], acc_lo_reg[WIDTH-1:1]};
                end
            end
            FIN: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
`ifdef MDU_DIV_EN
                if (is_div_reg) begin
                    if (div0_reg) begin
                        lo_next = '1;
                        hi_next = a_raw_reg;
                    end else begin
                        lo_next = q_fix;
                        hi_next = r_fix;
                    end
                end else
`endif
                begin
                    prod = neg_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
                    {hi_next, lo_next} = prod;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            b_reg       <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            neg_reg     <= 1'b0;
`ifdef MDU_DIV_EN
            is_div_reg  <= 1'b0;
            neg_r_reg   <= 1'b0;
            div0_reg    <= 1'b0;
            a_raw_reg   <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            illegal_reg <= illegal_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            b_reg       <= b_next;
            acc_hi_reg  <= acc_hi_next;
            acc_lo_reg  <= acc_lo_next;
            neg_reg     <= neg_next;
`ifdef MDU_DIV_EN
            is_div_reg  <= is_div_next;
            neg_r_reg   <= neg_r_next;
            div0_reg    <= div0_next;
            a_raw_reg   <= a_raw_next;
`endif
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign illegal_op = illegal_reg;
    assign hi         = hi_reg;
    assign lo         = lo_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit (WIDTH=32).
// Divide expectations follow MDU_DIV_EN (reserved-op behaviour when undefined).
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, done, illegal_op;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .illegal_op(illegal_op), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and watch until done (bounded), then compare everything
    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic e_ill, input int e_busy);
        int  busy_cycles = 0;
        bit  got_done = 0;
        bit  got_ill = 0;
        bit  stray_ill = 0;
        @(negedge clk);
        op = o; rs = a; rt = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                got_ill  = illegal_op;
                check("busy_at_done", busy, 1'b0);
            end else begin
                if (illegal_op) stray_ill = 1;
                if (busy) busy_cycles++;
            end
        end
        check("done", got_done, 1'b1);
        check("illegal", got_ill, e_ill);
        check("ill_no_done", stray_ill, 1'b0);
        check("busy_cycles", busy_cycles, e_busy);
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
        $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h ill=%0b busy_cycles=%0d",
                 o, a, b, hi, lo, got_ill, busy_cycles);
    endtask

    task automatic vec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
        exp_hi = h; exp_lo = l;
        run(o, a, b, 1'b0, (o < 3'd4) ? 33 : 0);
    endtask

    task automatic vec_ill(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        run(o, a, b, 1'b1, 0);
    endtask

    task automatic vec_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] h, input logic [31:0] l);
`ifdef MDU_DIV_EN
        vec(o, a, b, h, l);
`else
        vec_ill(o, a, b);
`endif
    endtask

    initial begin
        bit saw_done;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; rs = '0; rt = '0;
        repeat (2) @(negedge clk);
        // start asserted during reset must be ignored
        start = 1'b1; op = 3'd4; rs = 32'hFFFF_0000;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ill", illegal_op, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        vec(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        vec(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        vec(3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);
        vec(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        vec(3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
        vec_div(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        vec_div(3'd3, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF);
        vec_div(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        vec_div(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        vec_div(3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
        vec_div(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        vec_ill(3'd6, 32'h1111_1111, 32'h2222_2222);
        vec_ill(3'd7, 32'h3333_3333, 32'h4444_4444);

        // Start ignored while busy, then reset mid-operation
        @(negedge clk);
        op = 3'd0; rs = 32'h3; rt = 32'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 3'd4; rs = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid", busy, 1'b1);
        check("hi_ignored", hi, exp_hi);
        check("done_mid", done, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 1'b0);
        $display("reset mid-op: busy=%0b hi=%h lo=%h done_seen=%0b", busy, hi, lo, saw_done);
        exp_hi = 32'h0; exp_lo = 32'h0;

        // mthi then mtlo back-to-back (second start in the done cycle)
        @(negedge clk);
        op = 3'd4; rs = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        check("mthi_done", done, 1'b1);
        check("mthi_busy", busy, 1'b0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h0);
        op = 3'd5; rs = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_done", done, 1'b1);
        check("mtlo_ill", illegal_op, 1'b0);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        $display("mthi/mtlo: hi=%h lo=%h", hi, lo);
        @(negedge clk);
        check("post_done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width (>=8, even).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved.
REQ-006 rs  input  WIDTH  operand A (multiplicand/dividend/mthi-mtlo source).
REQ-007 rt  input  WIDTH  operand B (multiplier/divisor).
REQ-008 busy  output  1  operation in progress; registered.
REQ-009 done  output  1  one-cycle completion pulse; registered.
REQ-010 illegal_op  output  1  qualifies done; high for reserved or compiled-out op.
REQ-011 hi  output  WIDTH  Hi register (mfhi source).
REQ-012 lo  output  WIDTH  Lo register (mflo source).

Function
REQ-013 States IDLE, CALC, FIN; CALC is a WIDTH-cycle iterative loop (shift-add multiply, restoring divide), one bit per cycle.
REQ-014 IDLE + start + op 0-3: latch rs/rt (magnitudes for signed ops) and sign flags, go CALC, busy=1 next cycle.
REQ-015 CALC runs exactly WIDTH cycles then goes FIN; FIN applies sign correction, then goes IDLE.
REQ-016 Start sampled at edge N: busy high after edges N..N+WIDTH; at edge N+WIDTH+1 hi/lo update, done=1 for one cycle, busy=0.
REQ-017 Mult/multu: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
REQ-018 Div/divu: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-019 Divide by zero (div, divu): lo = all ones, hi = rs; no other flag.
REQ-020 Signed overflow (div, rs = most-negative, rt = -1): lo = rs, hi = 0.
REQ-021 mthi/mtlo: hi (resp. lo) = rs at the edge after start; done pulses that cycle; busy stays 0.
REQ-022 Reserved op: hi/lo unchanged; done and illegal_op high together one cycle after start.
REQ-023 start while busy=1 is ignored; no queuing, operands not re-latched.
REQ-024 start during the done cycle is accepted (back-to-back, no bubble).
REQ-025 hi/lo hold value between operations; change only per REQ-016/021.
REQ-026 illegal_op is 0 whenever done is 0.

Reset
REQ-027 rst_n=0 at an edge: state IDLE, busy=0, done=0, illegal_op=0, hi=0, lo=0.
REQ-028 Reset mid-operation aborts it; no done pulse, partial results discarded.
REQ-029 start is ignored in any cycle rst_n=0.

Configuration
REQ-030 Macro MDU_DIV_EN defined: div/divu per REQ-018..020.
REQ-031 MDU_DIV_EN undefined: no divider logic; ops 2-3 treated as reserved per REQ-022.

Verification
REQ-032 WIDTH=32, mult rs=7 rt=FFFFFFFD -> after 33 cycles done=1, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-033 multu rs=rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, busy high exactly 33 cycles.
REQ-034 div rs=FFFFFFF9 rt=2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu rs=A rt=0 -> lo=FFFFFFFF, hi=0000000A.
REQ-035 div rs=80000000 rt=FFFFFFFF -> lo=80000000, hi=0; op=6 -> done+illegal_op next cycle, hi/lo unchanged.
REQ-036 mult started, second start at cycle 5 ignored, rst_n low at cycle 10 -> no done, busy=0, hi=lo=0.
REQ-037 mthi rs=12345678 then mtlo rs=9ABCDEF0 back-to-back -> hi=12345678, lo=9ABCDEF0, two done pulses.
